flt_arbiter: RTL and testbench
==============================

Name: flt_arbiter

Overview:
- Shares one combinational `flt` (float32 less-than) comparator among NREQ requesters.
- Round-robin grant, one request accepted per cycle.
- Registered single-entry result stage with valid/ready backpressure.
- Sits between scalar issue ports (e.g. branch-compare and sort units) and the FPU compare resource.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of resp_id; must satisfy 2**IDW >= NREQ

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_x1  in  NREQ*32  operand x1 of requester i at bits [32*i+31:32*i]
req_x2  in  NREQ*32  operand x2 of requester i, same packing
resp_valid  out  1  result register holds a valid result
resp_ready  in  1  consumer accepts result
resp_y  out  1  registered x1 < x2 (IEEE float32 semantics)
resp_id  out  IDW  index of requester that produced resp_y

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: resp_valid=0, resp_y=0, resp_id=0, rr pointer=0. req_ready is 0 during the reset cycle.
- load = !resp_valid || resp_ready.
- grant:
  - One-hot pick among req_valid.
  - Search starts at index ptr and wraps modulo NREQ.
  - grant=0 when no req_valid is set.
- req_ready = grant & {NREQ{load}}.
  - req_ready does not depend combinationally on resp_ready except through load.
  - req_ready[i] never asserts unless req_valid[i].
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. Requesters hold x1/x2 stable while valid && !ready.
- On transfer from requester k:
  - Next cycle: resp_valid=1, resp_y=flt(x1_k,x2_k), resp_id=k.
  - ptr <= (k+1) mod NREQ.
- On load with no transfer: resp_valid <= 0. resp_y and resp_id hold their values.
- If resp_valid && !resp_ready: result, resp_valid and ptr all hold, and req_ready=0.
- Latency: 1 cycle from accept to resp_valid. Throughput: 1 result/cycle when resp_ready is held high.
- Compare semantics, identical to the `flt` datapath:
  - +0 and -0 are equal, so y=0.
  - Negative < positive.
  - For two negatives, larger magnitude is less.
  - Denormals are compared by bit pattern magnitude.
  - +inf and -inf are ordered.
- Fairness: a continuously asserted request is granted within NREQ accepting cycles.
- Boundary cases:
  - Single requester: back-to-back grants each cycle.
  - All requesters valid: grant order ptr, ptr+1, …
  - Reset asserted mid-stall: the pending result is discarded, with resp_valid=0 on the next cycle.

Optional Feature:
- Macro: FLT_ARB_NAN_EXC_EN.
- When defined:
  - Adds output `resp_exc` (1 bit, reset 0), registered alongside resp_y.
  - resp_exc=1 iff either operand has exp==8'hFF and mantissa!=0 (NaN).
  - When resp_exc=1, resp_y is forced to 0.
- When undefined:
  - No resp_exc port.
  - NaN inputs produce whatever the `flt` datapath yields; the value is unchecked.

Decomposition:
- Package `fpu_pkg`:
  - typedef float32_t (packed struct: sgn, exp[7:0], man[22:0]).
  - Constant EXP_MAX=8'hFF.
  - Function is_nan(float32_t).
- Sub-module `rr_pick`:
  - Parameter N.
  - Inputs: req[N], ptr[$clog2(N)].
  - Outputs: one-hot gnt[N] and idx.
  - Purely combinational.
- Existing `flt` is instantiated once on the granted operands through a mux.

Test Plan:
- Single request, resp_ready=1: requester 0 sends x1=0x3F800000 (1.0), x2=0x40000000 (2.0) -> next cycle resp_valid=1, resp_y=1, resp_id=0.
- Signed zero and negatives:
  - x1=0x80000000, x2=0x00000000 -> resp_y=0.
  - x1=0xC0000000 (-2.0), x2=0xBF800000 (-1.0) -> resp_y=1.
- All 4 requesters valid every cycle from ptr=0, resp_ready=1 -> resp_id sequence 0,1,2,3,0 on consecutive cycles; each req_ready pulses once per 4 cycles.
- Backpressure:
  - Hold resp_ready=0 for 3 cycles after a result -> resp_valid, resp_y, resp_id stable and req_ready=0 throughout.
  - On release -> next grant accepted in the same cycle.
- Reset during stall: assert rst while resp_valid=1, resp_ready=0 -> next cycle resp_valid=0, ptr=0, req_ready=0 during reset; the first grant after reset goes to the lowest valid index.
- With FLT_ARB_NAN_EXC_EN: x1=0x7FC00000, x2=0x3F800000 -> resp_exc=1, resp_y=0; with x1=0x7F800000 (+inf) -> resp_exc=0, resp_y=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - float32 field layout and classification helpers shared by the compare path
package fpu_pkg;

    typedef struct packed {
        logic        sgn;
        logic [7:0]  exp;
        logic [22:0] man;
    } float32_t;

    localparam logic [7:0] EXP_MAX = 8'hFF;

    function automatic logic is_nan(float32_t f);
        return (f.exp == EXP_MAX) && (f.man != '0);
    endfunction

endpackage

// File: rtl/flt.sv
// rtl/flt.sv - combinational float32 less-than (a < b), signed zeros equal, NaN unspecified
import fpu_pkg::*;

module flt (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt
);

    float32_t   fa;
    float32_t   fb;
    logic [30:0] mag_a;
    logic [30:0] mag_b;

    assign fa    = a;
    assign fb    = b;
    assign mag_a = {fa.exp, fa.man};
    assign mag_b = {fb.exp, fb.man};

    // Sign-magnitude ordering; the magnitude compare flips for two negatives.
    always_comb begin
        lt = 1'b0;
        if ((mag_a == '0) && (mag_b == '0)) begin
            lt = 1'b0;
        end else if (fa.sgn != fb.sgn) begin
            lt = fa.sgn;
        end else if (!fa.sgn) begin
            lt = (mag_a < mag_b);
        end else begin
            lt = (mag_a > mag_b);
        end
    end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set req at or after ptr, wrapping mod N
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int PW = $clog2(N);
    localparam int SW = PW + 1;

    logic [SW-1:0] sum;
    logic [PW-1:0] pos;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + SW'(off);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            pos = sum[PW-1:0];
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/flt_arbiter.sv
// rtl/flt_arbiter.sv - round-robin share of one flt comparator; FLT_ARB_NAN_EXC_EN adds resp_exc NaN flag
import fpu_pkg::*;

module flt_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_x1,
    input  logic [NREQ*32-1:0] req_x2,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_y,
`ifdef FLT_ARB_NAN_EXC_EN
    output logic               resp_exc,
`endif
    output logic [IDW-1:0]     resp_id
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  pick_idx;
    logic [NREQ-1:0] gnt;
    logic           load;
    logic           xfer;
    logic           lt;
    logic           y_new;
    logic [31:0]    op_x1;
    logic [31:0]    op_x2;
    logic           resp_valid_q, resp_valid_d;
    logic           resp_y_q, resp_y_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;

    rr_pick #(.N(NREQ)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (pick_idx)
    );

    assign load      = !resp_valid_q || resp_ready;
    assign req_ready = rst ? '0 : (gnt & {NREQ{load}});
    assign xfer      = |req_ready;

    // One-hot AND-OR operand mux driven directly by the grant.
    always_comb begin
        op_x1 = '0;
        op_x2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op_x1 = req_x1[32*i +: 32];
                op_x2 = req_x2[32*i +: 32];
            end
        end
    end

    flt u_flt (
        .a  (op_x1),
        .b  (op_x2),
        .lt (lt)
    );

`ifdef FLT_ARB_NAN_EXC_EN
    logic resp_exc_q, resp_exc_d;
    logic exc_new;

    assign exc_new = is_nan(float32_t'(op_x1)) || is_nan(float32_t'(op_x2));
    assign y_new   = exc_new ? 1'b0 : lt;

    always_comb begin
        resp_exc_d = resp_exc_q;
        if (load && xfer) begin
            resp_exc_d = exc_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_exc_q <= 1'b0;
        end else begin
            resp_exc_q <= resp_exc_d;
        end
    end

    assign resp_exc = resp_exc_q;
`else
    assign y_new = lt;
`endif

    // Result and pointer hold while stalled; an empty load cycle only drops valid.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_y_d     = resp_y_q;
        resp_id_d    = resp_id_q;
        ptr_d        = ptr_q;
        if (load) begin
            resp_valid_d = xfer;
            if (xfer) begin
                resp_y_d  = y_new;
                resp_id_d = IDW'(pick_idx);
                ptr_d     = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_y_q     <= 1'b0;
            resp_id_q    <= '0;
            ptr_q        <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_y_q     <= resp_y_d;
            resp_id_q    <= resp_id_d;
            ptr_q        <= ptr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_y     = resp_y_q;
    assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_flt_arbiter.sv
// tb/tb_flt_arbiter.sv - self-checking bench for flt_arbiter against a queue-free arithmetic reference model
module tb_flt_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_x1;
    logic [NREQ*32-1:0] req_x2;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_y;
    logic [IDW-1:0]     resp_id;
`ifdef FLT_ARB_NAN_EXC_EN
    logic               resp_exc;
`endif

    logic [31:0] x1 [NREQ];
    logic [31:0] x2 [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        req_x1 = '0;
        req_x2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_x1[32*i +: 32] = x1[i];
            req_x2[32*i +: 32] = x2[i];
        end
    end

    flt_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x1     (req_x1),
        .req_x2     (req_x2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
`ifdef FLT_ARB_NAN_EXC_EN
        .resp_exc   (resp_exc),
`endif
        .resp_id    (resp_id)
    );

    int n_cmp = 0;
    int n_err = 0;

    int              m_ptr;
    bit              m_valid;
    bit              m_y;
    int              m_id;
    bit              exp_load;
    logic [NREQ-1:0] exp_ready;
    int              exp_k;
    bit              exp_y_next;

    // Float order as integers: sign-magnitude mapped onto a signed number line.
    function automatic bit ref_lt(logic [31:0] a, logic [31:0] b);
        longint ka, kb;
        ka = longint'(a[30:0]);
        kb = longint'(b[30:0]);
        if (a[31]) ka = -ka;
        if (b[31]) kb = -kb;
        return ka < kb;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 7))
                0: t = 32'h0000_0000;
                1: t = 32'h8000_0000;
                2: t = 32'h7F80_0000;
                3: t = 32'hFF80_0000;
                4: t = 32'h0000_0001;
                5: t = 32'h8000_0001;
                6: t = 32'h3F80_0000;
                default: t = 32'hBF80_0000;
            endcase
        end
        if (t[30:23] == 8'hFF) t[22:0] = '0;
        return t;
    endfunction

    task automatic predict();
        exp_load  = !m_valid || resp_ready;
        exp_ready = '0;
        exp_k     = -1;
        if (!rst) begin
            for (int off = 0; off < NREQ; off++) begin
                int k;
                k = (m_ptr + off) % NREQ;
                if (exp_k < 0 && req_valid[k]) exp_k = k;
            end
        end
        if (!exp_load) exp_k = -1;
        if (exp_k >= 0) begin
            exp_ready[exp_k] = 1'b1;
            exp_y_next       = ref_lt(x1[exp_k], x2[exp_k]);
        end
    endtask

    task automatic commit();
        if (rst) begin
            m_ptr = 0; m_valid = 0; m_y = 0; m_id = 0;
        end else if (exp_load) begin
            m_valid = (exp_k >= 0);
            if (exp_k >= 0) begin
                m_y   = exp_y_next;
                m_id  = exp_k;
                m_ptr = (exp_k + 1) % NREQ;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        predict();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        resp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            predict();
            n_cmp++;
            if (req_ready !== '0) begin
                n_err++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
            end
            @(posedge clk);
            commit();
            #1;
            n_cmp++;
            if (resp_valid !== 1'b0 || resp_y !== 1'b0 || resp_id !== '0) begin
                n_err++; $display("FAIL reset_outputs: got v=%b y=%b id=%0d want 0/0/0", resp_valid, resp_y, resp_id);
            end
        end
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        x1[0] = 32'h3F80_0000;
        x2[0] = 32'h4000_0000;
        req_valid = 4'b0001;
        resp_ready = 1'b1;
        @(negedge clk);
        predict();
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        @(posedge clk);
        commit();
        #1;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_y !== 1'b1 || resp_id !== 2'd0) begin
            n_err++; $display("FAIL single_resp: got v=%b y=%b id=%0d want 1/1/0", resp_valid, resp_y, resp_id);
        end
        req_valid = '0;
    endtask

    task automatic test_signed();
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic        vy [2];
        va[0] = 32'h8000_0000; vb[0] = 32'h0000_0000; vy[0] = 1'b0;
        va[1] = 32'hC000_0000; vb[1] = 32'hBF80_0000; vy[1] = 1'b1;
        resp_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            x1[0] = va[t];
            x2[0] = vb[t];
            req_valid = 4'b0001;
            @(negedge clk);
            predict();
            n_cmp++;
            if (req_ready !== 4'b0001) begin
                n_err++; $display("FAIL signed_ready[%0d]: got %b want 0001", t, req_ready);
            end
            @(posedge clk);
            commit();
            #1;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_y !== vy[t] || resp_y !== m_y) begin
                n_err++; $display("FAIL signed_resp[%0d]: got v=%b y=%b want 1/%b", t, resp_valid, resp_y, vy[t]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_all_valid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = '1;
        resp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                x1[i] = rnd_op();
                x2[i] = rnd_op();
            end
            @(negedge clk);
            predict();
            n_cmp++;
            if (req_ready !== (4'b0001 << (c % NREQ))) begin
                n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, 4'b0001 << (c % NREQ));
            end
            @(posedge clk);
            commit();
            #1;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_id !== IDW'(c % NREQ) || resp_y !== m_y) begin
                n_err++; $display("FAIL rr_resp[%0d]: got v=%b id=%0d y=%b want 1/%0d/%b", c, resp_valid, resp_id, resp_y, c % NREQ, m_y);
            end
        end
    endtask

    task automatic test_backpressure();
        logic           hold_y;
        logic [IDW-1:0] hold_id;
        req_valid = '1;
        resp_ready = 1'b1;
        tick();
        n_cmp++;
        if (resp_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_first: got v=%b want 1", resp_valid);
        end
        hold_y  = resp_y;
        hold_id = resp_id;
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            predict();
            n_cmp++;
            if (req_ready !== '0) begin
                n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", c, req_ready);
            end
            @(posedge clk);
            commit();
            #1;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_y !== hold_y || resp_id !== hold_id) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b y=%b id=%0d want 1/%b/%0d", c, resp_valid, resp_y, resp_id, hold_y, hold_id);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        predict();
        n_cmp++;
        if (req_ready !== exp_ready || $countones(req_ready) != 1) begin
            n_err++; $display("FAIL bp_release: got %b want %b", req_ready, exp_ready);
        end
        @(posedge clk);
        commit();
        #1;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_id !== IDW'(m_id) || resp_y !== m_y) begin
            n_err++; $display("FAIL bp_after: got v=%b id=%0d y=%b want 1/%0d/%b", resp_valid, resp_id, resp_y, m_id, m_y);
        end
    endtask

    task automatic test_reset_stall();
        req_valid = '1;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        predict();
        n_cmp++;
        if (req_ready !== '0) begin
            n_err++; $display("FAIL rst_stall_ready: got %b want 0", req_ready);
        end
        @(posedge clk);
        commit();
        #1;
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_id !== '0) begin
            n_err++; $display("FAIL rst_stall_resp: got v=%b id=%0d want 0/0", resp_valid, resp_id);
        end
        rst = 1'b0;
        req_valid = 4'b1100;
        resp_ready = 1'b1;
        @(negedge clk);
        predict();
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL rst_first_grant: got %b want 0100", req_ready);
        end
        @(posedge clk);
        commit();
        #1;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2) begin
            n_err++; $display("FAIL rst_first_resp: got v=%b id=%0d want 1/2", resp_valid, resp_id);
        end
    endtask

    task automatic test_random();
        int wait_cnt [NREQ];
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        req_valid = '0;
        exp_ready = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || exp_ready[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    x1[i] = rnd_op();
                    x2[i] = ($urandom_range(0, 7) == 0) ? x1[i] : rnd_op();
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            predict();
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && exp_load) wait_cnt[i]++;
                if (exp_ready[i]) begin
                    n_cmp++;
                    if (wait_cnt[i] > NREQ) begin
                        n_err++; $display("FAIL rand_fair[%0d]: req %0d waited %0d want <=%0d", c, i, wait_cnt[i], NREQ);
                    end
                    wait_cnt[i] = 0;
                end
            end
            @(posedge clk);
            commit();
            #1;
            n_cmp++;
            if (resp_valid !== m_valid || resp_y !== m_y || resp_id !== IDW'(m_id)) begin
                n_err++; $display("FAIL rand_resp[%0d]: got v=%b y=%b id=%0d want %b/%b/%0d", c, resp_valid, resp_y, resp_id, m_valid, m_y, m_id);
            end
        end
        req_valid = '0;
    endtask

`ifdef FLT_ARB_NAN_EXC_EN
    task automatic test_nan_exc();
        logic [31:0] va [2];
        logic        ve [2];
        va[0] = 32'h7FC0_0000; ve[0] = 1'b1;
        va[1] = 32'h7F80_0000; ve[1] = 1'b0;
        resp_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            x1[0] = va[t];
            x2[0] = 32'h3F80_0000;
            req_valid = 4'b0001;
            tick();
            m_y = 1'b0;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_exc !== ve[t] || resp_y !== 1'b0) begin
                n_err++; $display("FAIL nan_exc[%0d]: got v=%b exc=%b y=%b want 1/%b/0", t, resp_valid, resp_exc, resp_y, ve[t]);
            end
        end
        req_valid = '0;
    endtask
`endif

    initial begin
        m_ptr = 0; m_valid = 0; m_y = 0; m_id = 0;
        exp_load = 0; exp_ready = '0; exp_k = -1; exp_y_next = 0;
        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            x1[i] = '0;
            x2[i] = '0;
        end
        test_reset();
        test_single();
        test_signed();
        test_all_valid();
        test_backpressure();
        test_reset_stall();
        test_random();
`ifdef FLT_ARB_NAN_EXC_EN
        test_nan_exc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
